// File: rtl/coverfloat_pkg.sv
// coverfloat_pkg: covervector field widths, packed vector layout and stream FSM states.
`define COVER_VECTOR_WIDTH 804

package coverfloat_pkg;
    localparam int OP_W   = 32;
    localparam int RM_W   = 8;
    localparam int OPND_W = 128;
    localparam int FMT_W  = 8;
    localparam int RES_W  = 128;
    localparam int EXC_W  = 8;
    localparam int DISC_W = 3;
    localparam int INTX_W = 32;
    localparam int INTM_W = 192;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RM_W-1:0]   rm;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] c;
        logic [FMT_W-1:0]  operandFmt;
        logic [RES_W-1:0]  result;
        logic [FMT_W-1:0]  resultFmt;
        logic [EXC_W-1:0]  exceptionBits;
        logic [DISC_W-1:0] discard;
        logic              intermS;
        logic [INTX_W-1:0] intermX;
        logic [INTM_W-1:0] intermM;
    } covervector_t;

    typedef enum logic [1:0] {
        ST_ASSEMBLE,
        ST_HOLD,
        ST_DISCARD
    } state_t;
endpackage

// File: rtl/coverfloat_vector_assembler.sv
// coverfloat_vector_assembler: beat counter, frame shift register and framing FSM.
module coverfloat_vector_assembler
    import coverfloat_pkg::*;
#(
    parameter int BEAT_W    = 32,
    parameter int NUM_BEATS = 26
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [BEAT_W-1:0]           s_data_i,
    input  logic                        s_last_i,
    input  logic                        out_free_i,
    output logic                        xfer_o,
    output logic                        err_o,
    output logic [BEAT_W*NUM_BEATS-1:0] frame_o
);
    localparam int FW = BEAT_W * NUM_BEATS;
    localparam int CW = $clog2(NUM_BEATS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] sr_q, sr_d, shifted;
    logic          s_ready_q, acc, at_end;

    assign acc       = s_valid_i && s_ready_q;
    assign at_end    = cnt_q == CW'(NUM_BEATS - 1);
    assign shifted   = {sr_q[FW-BEAT_W-1:0], s_data_i};
    assign s_ready_o = s_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ASSEMBLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            s_ready_q <= state_d != ST_HOLD;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = (state_q == ST_ASSEMBLE && acc) ? shifted : sr_q;
        case (state_q)
            ST_ASSEMBLE: if (acc) begin
                cnt_d = (at_end || s_last_i) ? '0 : cnt_q + CW'(1);
                if (at_end)
                    state_d = !s_last_i ? ST_DISCARD : (out_free_i ? ST_ASSEMBLE : ST_HOLD);
            end
            ST_HOLD: if (out_free_i) state_d = ST_ASSEMBLE;
            default: if (acc && s_last_i) state_d = ST_ASSEMBLE;
        endcase
    end

    // A completed frame bypasses the shift register unless it had to wait in HOLD
    always_comb begin
        xfer_o  = (state_q == ST_ASSEMBLE && acc && at_end && s_last_i && out_free_i)
               || (state_q == ST_HOLD && out_free_i);
        err_o   = state_q == ST_ASSEMBLE && acc && (s_last_i != at_end);
        frame_o = state_q == ST_HOLD ? sr_q : shifted;
    end
endmodule

// File: rtl/coverfloat_vector_stream.sv
// coverfloat_vector_stream: assembles covervector beats into unpacked output fields.
// Define COVERFLOAT_FIELD_CHECK_EN to flag vectors with nonzero discard or padding bits.
module coverfloat_vector_stream
    import coverfloat_pkg::*;
#(
    parameter int BEAT_W    = 32,
    parameter int NUM_BEATS = (`COVER_VECTOR_WIDTH + BEAT_W - 1) / BEAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_op,
    output logic [7:0]        m_rm,
    output logic [127:0]      m_a,
    output logic [127:0]      m_b,
    output logic [127:0]      m_c,
    output logic [7:0]        m_operandFmt,
    output logic [127:0]      m_result,
    output logic [7:0]        m_resultFmt,
    output logic [7:0]        m_exceptionBits,
    output logic              m_intermS,
    output logic [31:0]       m_intermX,
    output logic [191:0]      m_intermM,
    output logic [31:0]       m_vectornum,
    output logic              m_field_err,
    output logic              frame_err,
    output logic [15:0]       frame_err_cnt
);
    localparam int FW = BEAT_W * NUM_BEATS;

    logic [FW-1:0] frame;
    logic          xfer, err, hs, unused_bits;
    covervector_t  cv, vec_q, vec_d;
    logic          m_valid_q, m_valid_d, frame_err_q, frame_err_d;
    logic [31:0]   vnum_q, vnum_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    assign hs = m_valid_q && m_ready;
    assign cv = frame[`COVER_VECTOR_WIDTH-1:0];

    coverfloat_vector_assembler #(.BEAT_W(BEAT_W), .NUM_BEATS(NUM_BEATS)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .s_data_i   (s_data),
        .s_last_i   (s_last),
        .out_free_i (!m_valid_q || m_ready),
        .xfer_o     (xfer),
        .err_o      (err),
        .frame_o    (frame)
    );

    always_comb begin
        vec_d       = xfer ? cv : vec_q;
        m_valid_d   = xfer || (m_valid_q && !m_ready);
        vnum_d      = hs ? vnum_q + 32'd1 : vnum_q;
        frame_err_d = err;
        err_cnt_d   = (err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_q       <= '0;
            m_valid_q   <= 1'b0;
            vnum_q      <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            vec_q       <= vec_d;
            m_valid_q   <= m_valid_d;
            vnum_q      <= vnum_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef COVERFLOAT_FIELD_CHECK_EN
    logic field_err_q, field_err_d;
    always_comb field_err_d = xfer ? (|cv.discard || |frame[FW-1:`COVER_VECTOR_WIDTH]) : field_err_q;
    always_ff @(posedge clk) field_err_q <= reset ? 1'b0 : field_err_d;
    assign m_field_err = field_err_q;
    assign unused_bits = ^vec_q.discard;
`else
    assign m_field_err = 1'b0;
    assign unused_bits = ^{vec_q.discard, frame[FW-1:`COVER_VECTOR_WIDTH]};
`endif

    assign m_valid         = m_valid_q;
    assign m_op            = vec_q.op;
    assign m_rm            = vec_q.rm;
    assign m_a             = vec_q.a;
    assign m_b             = vec_q.b;
    assign m_c             = vec_q.c;
    assign m_operandFmt    = vec_q.operandFmt;
    assign m_result        = vec_q.result;
    assign m_resultFmt     = vec_q.resultFmt;
    assign m_exceptionBits = vec_q.exceptionBits;
    assign m_intermS       = vec_q.intermS;
    assign m_intermX       = vec_q.intermX;
    assign m_intermM       = vec_q.intermM;
    assign m_vectornum     = vnum_q;
    assign frame_err       = frame_err_q;
    assign frame_err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_coverfloat_vector_stream.sv
// tb_coverfloat_vector_stream: directed framing, back-pressure, reset and field-check vectors.
module tb_coverfloat_vector_stream;
    import coverfloat_pkg::*;

    typedef struct packed {
        covervector_t v;
        logic         fe;
    } exp_t;

    logic         clk, reset, s_valid, s_ready, s_last, m_valid, m_ready;
    logic [31:0]  s_data, m_op, m_intermX, m_vectornum;
    logic [7:0]   m_rm, m_operandFmt, m_resultFmt, m_exceptionBits;
    logic [127:0] m_a, m_b, m_c, m_result;
    logic [191:0] m_intermM;
    logic         m_intermS, m_field_err, frame_err;
    logic [15:0]  frame_err_cnt;

    int   checks = 0, passed = 0, err_seen = 0, exp_vnum = 0;
    exp_t exp_q[$];
    exp_t e;

    coverfloat_vector_stream dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_op(m_op), .m_rm(m_rm),
        .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_operandFmt(m_operandFmt), .m_result(m_result),
        .m_resultFmt(m_resultFmt), .m_exceptionBits(m_exceptionBits), .m_intermS(m_intermS),
        .m_intermX(m_intermX), .m_intermM(m_intermM), .m_vectornum(m_vectornum),
        .m_field_err(m_field_err), .frame_err(frame_err), .frame_err_cnt(frame_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [831:0] got, input logic [831:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic covervector_t mkvec(input logic [31:0] k);
        covervector_t v;
        v.op            = k;
        v.rm            = 8'(k);
        v.a             = {4{32'hA5A5_0000 | k}};
        v.b             = {4{32'h5A5A_0000 ^ (k << 4)}};
        v.c             = {k, 96'h0123_4567_89AB_CDEF_0011_2233};
        v.operandFmt    = 8'h10 + 8'(k);
        v.result        = {2{64'hFEDC_BA98_7654_3210 ^ {32'h0, k}}};
        v.resultFmt     = 8'h20;
        v.exceptionBits = 8'h1F;
        v.discard       = 3'b000;
        v.intermS       = k[0];
        v.intermX       = ~k;
        v.intermM       = {6{32'h1357_9BDF + k}};
        return v;
    endfunction

    task automatic beat(input logic [31:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!s_ready) check("s_ready_timeout", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vec(input covervector_t v, input logic [27:0] pad, input bit expect_out);
        logic [831:0] fr;
        exp_t x;
        fr = {pad, v};
        x.v = v;
`ifdef COVERFLOAT_FIELD_CHECK_EN
        x.fe = (v.discard != 3'b000) || (pad != 28'h0);
`else
        x.fe = 1'b0;
`endif
        if (expect_out) exp_q.push_back(x);
        for (int i = 0; i < 26; i++) beat(fr[831-32*i -: 32], i == 25);
        if (expect_out && m_ready) begin
            check("latency_valid", m_valid, 1);
            check("latency_op", m_op, v.op);
        end
    endtask

    task automatic send_raw(input int n, input int last_idx);
        for (int i = 0; i < n; i++) beat(32'hC0DE_0000 + 32'(i), i == last_idx);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {m_valid, s_ready, frame_err, m_field_err}, 0);
        check({tag, "_fields"}, {m_op, m_rm, m_a, m_b, m_c, m_operandFmt, m_result, m_resultFmt,
                                 m_exceptionBits, m_intermS, m_intermX, m_intermM}, 0);
        check({tag, "_vnum"}, m_vectornum, 0);
        check({tag, "_errcnt"}, frame_err_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_vnum = 0;
            err_seen = 0;
        end else begin
            if (frame_err) err_seen++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_vec", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_op", m_op, e.v.op);
                    check("out_fields",
                          {m_rm, m_a, m_b, m_c, m_operandFmt, m_result, m_resultFmt,
                           m_exceptionBits, m_intermS, m_intermX, m_intermM},
                          {e.v.rm, e.v.a, e.v.b, e.v.c, e.v.operandFmt, e.v.result, e.v.resultFmt,
                           e.v.exceptionBits, e.v.intermS, e.v.intermX, e.v.intermM});
                    check("out_vnum", m_vectornum, 32'(exp_vnum));
                    check("out_field_err", m_field_err, e.fe);
                    exp_vnum++;
                end
            end
        end
    end

    initial begin
        covervector_t v;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle("rst");
        reset = 1'b0;

        for (int i = 1; i <= 3; i++) send_vec(mkvec(32'(i)), 28'h0, 1'b1);
        drain();

        m_ready = 1'b0;
        send_vec(mkvec(32'h4), 28'h0, 1'b1);
        send_vec(mkvec(32'h5), 28'h0, 1'b1);
        check("hold_sready", s_ready, 0);
        check("hold_op", m_op, 32'h4);
        repeat (8) @(posedge clk);
        #1 check("hold_stable", {m_valid, m_op}, {1'b1, 32'h4});
        m_ready = 1'b1;
        drain();
        check("resume_sready", s_ready, 1);

        do_reset();
        send_raw(11, 10);
        check("early_pulse", frame_err, 1);
        check("early_cnt", frame_err_cnt, 1);
        send_vec(mkvec(32'h6), 28'h0, 1'b1);
        drain();
        check("early_pulses", err_seen, 1);

        do_reset();
        send_raw(30, 29);
        check("missing_cnt", frame_err_cnt, 1);
        send_vec(mkvec(32'h7), 28'h0, 1'b1);
        drain();
        check("missing_pulses", err_seen, 1);

        m_ready = 1'b0;
        send_vec(mkvec(32'h8), 28'h0, 1'b0);
        send_raw(13, -1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle("midrst");
        reset   = 1'b0;
        m_ready = 1'b1;
        send_vec(mkvec(32'h9), 28'h0, 1'b1);
        drain();
        check("midrst_errcnt", frame_err_cnt, 0);

        v = mkvec(32'hA);
        v.discard = 3'b010;
        send_vec(v, 28'h0, 1'b1);
        send_vec(mkvec(32'hB), 28'h800_0001, 1'b1);
        send_vec(mkvec(32'hC), 28'h0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/coverfloat_vector_stream.md
# coverfloat_vector_stream

Streaming front end for the coverfloat coverage stage. It receives covervectors as 32-bit beats over a valid/ready stream, assembles full `COVER_VECTOR_WIDTH` vectors, and checks framing. It unpacks each vector into the same fields the coverage sampler consumes (op, rm, a, b, c, operandFmt, result, resultFmt, exceptionBits, intermS, intermX, intermM) and presents one vector per output handshake with a running vector number. It sits directly upstream of the coverage sampling stage and replaces file-driven vector injection when vectors arrive from a loader or DMA.

## Interface
- Parameters:
- `BEAT_W`, 32: input beat width.
- `NUM_BEATS`, ceil(`COVER_VECTOR_WIDTH`/`BEAT_W`) = 26: beats per vector.
- Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `s_valid` / `s_ready`  in / out  1 / 1  input beat handshake.
- `s_data`  in  `BEAT_W`  beat payload; the first beat of a vector is its most significant word.
- `s_last`  in  1  marks the final beat of a vector.
- `m_valid` / `m_ready`  out / in  1 / 1  output vector handshake.
- `m_op` 32, `m_rm` 8, `m_a` `m_b` `m_c` 128 each, `m_operandFmt` 8, `m_result` 128, `m_resultFmt` 8, `m_exceptionBits` 8, `m_intermS` 1, `m_intermX` 32, `m_intermM` 192  out  unpacked fields.
- `m_vectornum`  out  32  index of the presented vector, starting at 0.
- `m_field_err`  out  1  field check failed for the presented vector.
- `frame_err`  out  1  one-cycle pulse per framing error.
- `frame_err_cnt`  out  16  saturating count of framing errors.

## Operation
- Vector layout, MSB first: op, rm, a, b, c, operandFmt, result, resultFmt, exceptionBits, discard[2:0], intermS, intermX, intermM. The total is 804 bits.
- The vector is right-aligned in a 26×32 = 832-bit frame. The top 28 bits of beat 0 are padding and are ignored.
- A beat is accepted when `s_valid && s_ready`. A beat counter `beat_cnt` (0..NUM_BEATS-1) shifts each accepted beat into the assembly register.
- FSM states:
  - ASSEMBLE: `s_ready`=1.
    - `s_last` with `beat_cnt`==NUM_BEATS-1: the frame is complete. If the output register is empty, or `m_ready` is high this cycle, transfer the frame to the output register and stay in ASSEMBLE with `beat_cnt`=0. Otherwise go to HOLD.
    - `s_last` with `beat_cnt`<NUM_BEATS-1: early last. Pulse `frame_err`, drop the partial frame, set `beat_cnt`=0.
    - No `s_last` at `beat_cnt`==NUM_BEATS-1: missing last. Pulse `frame_err` and go to DISCARD.
  - HOLD: `s_ready`=0. When the output register frees (`m_valid && m_ready`), transfer the frame and return to ASSEMBLE.
  - DISCARD: `s_ready`=1. Drop beats until a beat with `s_last` is accepted, then return to ASSEMBLE with `beat_cnt`=0.
- `m_vectornum` increments by 1 on each output handshake and wraps at 2^32.
- `frame_err_cnt` saturates at 0xFFFF.
- The output register holds all fields stable while `m_valid && !m_ready`.
- Reset values: all outputs 0, state ASSEMBLE, `beat_cnt`=0. Reset mid-frame discards the partial frame and any held vector, and does not count an error.

## Timing
- Latency: the last beat is accepted in cycle N; `m_valid`=1 in cycle N+1.
- Throughput: one vector per NUM_BEATS cycles with no stall, because output consumption overlaps assembly.
- When a frame completes in the same cycle the output handshakes, the new vector appears in N+1 with no bubble.
- `s_ready` is registered, derived from the state only. `m_valid` is registered.

## Configuration
- `COVERFLOAT_FIELD_CHECK_EN`
  - Defined: on transfer to the output register, set `m_field_err`=1 if discard[2:0]≠0 or the padding bits ≠0. The vector is still delivered.
  - Undefined: `m_field_err` is tied to 0 and the check logic is absent.

## Structure
- Package `coverfloat_pkg` holds:
  - the field width localparams;
  - the `COVER_VECTOR_WIDTH` macro;
  - the packed struct `covervector_t` in the layout order above;
  - the FSM state enum.
- Sub-module `coverfloat_vector_assembler` contains the beat counter, the shift register and the FSM. The top level contains the output register, the counters and the field check.

## Test plan
- Stream 3 well-formed vectors back-to-back with `m_ready`=1 and op=0x1,0x2,0x3 → three outputs with `m_vectornum` 0,1,2, fields matching a bit-exact unpack, and each `m_valid` one cycle after its last beat.
- `m_ready`=0 for 60 cycles while 2 vectors stream → the first vector is held stable, `s_ready` drops on completion of the second, and both vectors are delivered in order once `m_ready`=1.
- Early `s_last` on beat 10, followed by a good vector → `frame_err` pulses once, `frame_err_cnt`=1, only the good vector is output with vectornum 0.
- Missing `s_last` on beat 25, last asserted on beat 29, then a good vector → one error, beats 26–29 are discarded, the good vector is delivered.
- Assert `reset` at beat 13 → all outputs 0, `frame_err_cnt` unchanged at 0, and the next full vector is delivered correctly.
- With `COVERFLOAT_FIELD_CHECK_EN` defined and discard=3'b010 → the vector is delivered with `m_field_err`=1. With the macro undefined, `m_field_err`=0.
